// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/READ/EXEC/MEM/WB sequencer with register file,
// ALU, program-loadable instruction memory, word-addressed data memory and a sticky error flag.
module multicycle_core #(
    parameter int DATA_W     = 8,
    parameter int NREGS      = 32,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16,
    parameter int MAX_PC     = 11,
    parameter int OUTPUT_REG = 4,
    localparam int PC_W      = $clog2(IMEM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_prog_we,
    input  logic [PC_W-1:0]   i_prog_addr,
    input  logic [31:0]       i_prog_data,
    output logic [2:0]        o_state,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_done,
    output logic [DATA_W-1:0] o_out_value,
    output logic              o_err
);
    localparam int RA_W = $clog2(NREGS);
    localparam int DA_W = $clog2(DMEM_DEPTH);
    localparam logic [PC_W-1:0] HALT_PC = PC_W'(MAX_PC);
    localparam logic [RA_W-1:0] OUT_IDX = RA_W'(OUTPUT_REG);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_IDLE   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_ALU  = 3'd0,
        C_ADDI = 3'd1,
        C_LW   = 3'd2,
        C_SW   = 3'd3,
        C_BEQ  = 3'd4,
        C_BNE  = 3'd5,
        C_J    = 3'd6,
        C_BAD  = 3'd7
    } cls_t;

    typedef enum logic [2:0] {
        A_ADD = 3'd0,
        A_SUB = 3'd1,
        A_AND = 3'd2,
        A_OR  = 3'd3,
        A_SLT = 3'd4
    } aluop_t;

    state_t            r_state;
    state_t            w_state_next;
    state_t            w_fin;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_next;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_ir;
    cls_t              r_cls;
    cls_t              w_cls;
    aluop_t            r_aluop;
    aluop_t            w_aluop;
    logic [RA_W-1:0]   r_dst;
    logic [RA_W-1:0]   w_dst;
    logic [DATA_W-1:0] r_imm;
    logic [PC_W-1:0]   r_boff;
    logic [PC_W-1:0]   r_jt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] w_opb;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_wb;
    logic              w_eq;

    logic [31:0]       r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];
    logic [DATA_W-1:0] r_regs [NREGS];

    assign w_opb = (r_cls == C_ALU) ? r_b : r_imm;
    assign w_eq  = (r_a == r_b);
    assign w_wb  = (r_cls == C_LW) ? r_mdr : r_alu;

    // Instruction class, ALU operation and destination register from the fetched word
    always_comb begin
        w_cls   = C_BAD;
        w_aluop = A_ADD;
        w_dst   = r_ir[16 +: RA_W];
        case (r_ir[31:26])
            6'd0: begin
                w_dst = r_ir[11 +: RA_W];
                case (r_ir[5:0])
                    6'd32:   begin w_cls = C_ALU; w_aluop = A_ADD; end
                    6'd34:   begin w_cls = C_ALU; w_aluop = A_SUB; end
                    6'd36:   begin w_cls = C_ALU; w_aluop = A_AND; end
                    6'd37:   begin w_cls = C_ALU; w_aluop = A_OR;  end
                    6'd42:   begin w_cls = C_ALU; w_aluop = A_SLT; end
                    default: begin w_cls = C_BAD; w_aluop = A_ADD; end
                endcase
            end
            6'd8:    w_cls = C_ADDI;
            6'd35:   w_cls = C_LW;
            6'd43:   w_cls = C_SW;
            6'd4:    w_cls = C_BEQ;
            6'd5:    w_cls = C_BNE;
            6'd2:    w_cls = C_J;
            default: w_cls = C_BAD;
        endcase
    end

    // ALU; slt compares as two's-complement
    always_comb begin
        w_alu = {DATA_W{1'b0}};
        case (r_aluop)
            A_ADD:   w_alu = r_a + w_opb;
            A_SUB:   w_alu = r_a - w_opb;
            A_AND:   w_alu = r_a & w_opb;
            A_OR:    w_alu = r_a | w_opb;
            A_SLT:   w_alu = ($signed(r_a) < $signed(w_opb)) ? DATA_W'(1'b1) : {DATA_W{1'b0}};
            default: w_alu = {DATA_W{1'b0}};
        endcase
    end

    // Program counter update: increment in FETCH, redirect in EXEC (pc already points past the branch)
    always_comb begin
        w_pc_next = r_pc;
        case (r_state)
            S_FETCH: w_pc_next = r_pc + PC_W'(1'b1);
            S_EXEC: begin
                case (r_cls)
                    C_BEQ:   w_pc_next = w_eq ? (r_pc + r_boff) : r_pc;
                    C_BNE:   w_pc_next = w_eq ? r_pc : (r_pc + r_boff);
                    C_J:     w_pc_next = r_jt;
                    default: w_pc_next = r_pc;
                endcase
            end
            default: w_pc_next = r_pc;
        endcase
    end

    // Next-state logic; every instruction ends by comparing its final pc against the halt address
    always_comb begin
        w_state_next = r_state;
        w_fin        = (w_pc_next == HALT_PC) ? S_HALT : S_FETCH;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: w_state_next = S_READ;
            S_READ:   w_state_next = S_EXEC;
            S_EXEC: begin
                case (r_cls)
                    C_ALU, C_ADDI: w_state_next = S_WB;
                    C_LW, C_SW:    w_state_next = S_MEM;
                    default:       w_state_next = w_fin;
                endcase
            end
            S_MEM: begin
                if (r_cls == C_LW) begin
                    w_state_next = S_WB;
                end else begin
                    w_state_next = w_fin;
                end
            end
            S_WB:    w_state_next = w_fin;
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Sequencer state, program counter and done flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= {PC_W{1'b0}};
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_done  <= (w_state_next == S_HALT);
        end
    end

    // Sticky error flag, set when an undecodable instruction reaches EXEC
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else if (r_state == S_EXEC && r_cls == C_BAD) begin
            r_err <= 1'b1;
        end
    end

    // Datapath pipeline registers: IR, decoded fields, operands, ALU result, memory data
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ir    <= 32'd0;
            r_cls   <= C_BAD;
            r_aluop <= A_ADD;
            r_dst   <= {RA_W{1'b0}};
            r_imm   <= {DATA_W{1'b0}};
            r_boff  <= {PC_W{1'b0}};
            r_jt    <= {PC_W{1'b0}};
            r_a     <= {DATA_W{1'b0}};
            r_b     <= {DATA_W{1'b0}};
            r_alu   <= {DATA_W{1'b0}};
            r_mdr   <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                S_FETCH: r_ir <= r_imem[r_pc];
                S_DECODE: begin
                    r_cls   <= w_cls;
                    r_aluop <= w_aluop;
                    r_dst   <= w_dst;
                    r_imm   <= DATA_W'($signed(r_ir[15:0]));
                    r_boff  <= PC_W'(r_ir[15:0]);
                    r_jt    <= r_ir[PC_W-1:0];
                end
                S_READ: begin
                    r_a <= r_regs[r_ir[21 +: RA_W]];
                    r_b <= r_regs[r_ir[16 +: RA_W]];
                end
                S_EXEC: r_alu <= w_alu;
                S_MEM: begin
                    if (r_cls == C_LW) begin
                        r_mdr <= r_dmem[r_alu[DA_W-1:0]];
                    end
                end
                default: r_mdr <= r_mdr;
            endcase
        end
    end

    // Register file; register 0 is never written so it always reads zero
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if (r_state == S_WB && r_dst != {RA_W{1'b0}}) begin
            r_regs[r_dst] <= w_wb;
        end
    end

    // Data memory, cleared on reset; address is the ALU result modulo the depth
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                r_dmem[i] <= {DATA_W{1'b0}};
            end
        end else if (r_state == S_MEM && r_cls == C_SW) begin
            r_dmem[r_alu[DA_W-1:0]] <= r_b;
        end
    end

    // Instruction memory keeps its contents across reset; loadable only while idle
    always_ff @(posedge i_clk) begin
        if (!i_reset && r_state == S_IDLE && i_prog_we) begin
            r_imem[i_prog_addr] <= i_prog_data;
        end
    end

    assign o_state     = r_state;
    assign o_pc        = r_pc;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_out_value = r_regs[OUT_IDX];

endmodule
